parking_lot_tracker: RTL and testbench
======================================

# parking_lot_tracker

Parametrised parking-lot occupancy tracker that replaces the fixed 3-space / 8-hour lot datapath. It counts cars from pre-conditioned entry/exit pulses, logs occupancy once per hour into an internal NUM_HOURS-deep log, and detects rush hour itself instead of taking start/end strobes from a controller. At end of day it replays the log in a ping-pong sweep with a programmable per-address dwell. It sits between the input conditioning stage and the HEX display/decoder stage; all outputs are binary, and display encoding stays downstream.

## Interface

- CAPACITY, 3: number of spaces; must be ≥ 1
- NUM_HOURS, 8: hours per workday, which is also the log depth; must be ≥ 1
- DWELL, 50_000_000: clock cycles each playback address is held (1 s at 50 MHz); must be ≥ 1
- Derived widths: CNT_W = $clog2(CAPACITY+1), HR_W = $clog2(NUM_HOURS+1), AD_W = max(1, $clog2(NUM_HOURS))
- clock  in  1  sole clock; all state updates on posedge
- reset_n  in  1  synchronous, active-low reset
- enter  in  1  one-cycle pulse: a car arrived
- exit  in  1  one-cycle pulse: a car left
- hour_inc  in  1  one-cycle pulse: advance the hour
- count  out  CNT_W  cars currently in the lot
- free  out  CNT_W  CAPACITY − count
- full  out  1  count == CAPACITY
- rejected  out  1  one-cycle pulse: enter was ignored because the lot was full
- hour  out  HR_W  hours elapsed, 0..NUM_HOURS
- day_done  out  1  hour == NUM_HOURS
- rush_start, rush_end  out  HR_W each  latched rush-hour bounds; all-ones means none
- rush_valid  out  1  day_done and both rush bounds latched
- play_addr  out  AD_W  log address being replayed
- play_data  out  CNT_W  log[play_addr]
- play_valid  out  1  playback active

## Operation

- Reset (reset_n = 0 at an edge) takes priority over everything and can occur mid-day or mid-playback. It clears count, hour, the log, rejected, day_done, rush_valid, play_addr, play_data and play_valid to 0, sets free to CAPACITY, and sets rush_start/rush_end to all-ones. The FSM returns to RUN.
- FSM states:
  - RUN: the day is in progress. Go to PLAY_UP on the edge where hour becomes NUM_HOURS.
  - PLAY_UP: play_addr counts up 0 → NUM_HOURS−1.
  - PLAY_DOWN: play_addr counts down NUM_HOURS−2 → 1, then returns to PLAY_UP at address 0.
  - The sweep repeats until reset. With NUM_HOURS = 8 the sequence is 0..7, 6..1, 0.. . With NUM_HOURS ≤ 2, PLAY_DOWN is skipped; with NUM_HOURS = 1, play_addr stays at 0.
- Occupancy (RUN only):
  - enter alone: if not full, count increments; if full, count holds and rejected pulses.
  - exit alone: if count > 0, count decrements; at 0, exit is silently ignored.
  - enter and exit together: count is unchanged and rejected stays 0.
- Hour (RUN only): on hour_inc, log[hour] ← the pre-update value of count, then hour increments. After day_done, hour_inc, enter and exit are all ignored.
- Rush detection (RUN only), using the pre-update hour:
  - rush_start latches hour on the first count transition to CAPACITY in the day.
  - rush_end latches hour on the first transition to 0 that occurs after rush_start has latched.
  - Each bound latches once per day.
- rush_valid = day_done & both bounds latched. If the lot never filled, or never emptied after filling, the bounds keep their all-ones sentinel.
- In both play states, the dwell counter runs 0..DWELL−1 and play_addr advances when it wraps.

## Timing

- count, free, full, rejected, hour and the log update on the edge that samples the pulse, so the result is visible in the next cycle.
- day_done rises on the edge of the NUM_HOURS-th hour_inc. On that same edge, play_valid rises and play_addr = 0.
- play_addr and play_data are registered together and always aligned. Each address is held exactly DWELL cycles.
- hour_inc in the same cycle as enter or exit: the log stores the count before that enter/exit, and any rush bound latches the pre-increment hour.
- Counter widths are exact: count and hour never wrap.

## Test plan

- CAPACITY=3, NUM_HOURS=8, DWELL=2. Send 3 enters, then 1 more enter → count=3, full=1, free=0, rejected pulses once and count stays 3.
- Send enter and exit in the same cycle at count=1 → count stays 1; then 2 exits from count=1 → count=0, no underflow.
- Fill the lot during hour 2 and empty it during hour 5, then issue 8 hour_inc → rush_start=2, rush_end=5, rush_valid=1, day_done=1, and hour stays 8 after an extra hour_inc.
- Run a day that fills but never empties → rush_start latched, rush_end=all-ones, rush_valid=0.
- Log counts 0,1,2,3,3,2,1,0, then observe playback → address sequence 0..7,6..1,0 with each address held 2 cycles and play_data matching the logged value.
- Assert reset_n=0 for one cycle mid-playback → all outputs return to their reset values; a new day then logs correctly from hour 0.

Source files
------------

// File: rtl/parking_lot_tracker.sv
// Parking-lot occupancy tracker: counts cars, logs occupancy hourly, latches rush-hour
// bounds and replays the day's log in a ping-pong sweep with a per-address dwell.
module parking_lot_tracker #(
    parameter int CAPACITY  = 3,
    parameter int NUM_HOURS = 8,
    parameter int DWELL     = 50_000_000,
    localparam int CNT_W    = $clog2(CAPACITY + 1),
    localparam int HR_W     = $clog2(NUM_HOURS + 1),
    localparam int AD_W     = (NUM_HOURS > 2) ? $clog2(NUM_HOURS) : 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enter,
    input  logic             exit,
    input  logic             hour_inc,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] free,
    output logic             full,
    output logic             rejected,
    output logic [HR_W-1:0]  hour,
    output logic             day_done,
    output logic [HR_W-1:0]  rush_start,
    output logic [HR_W-1:0]  rush_end,
    output logic             rush_valid,
    output logic [AD_W-1:0]  play_addr,
    output logic [CNT_W-1:0] play_data,
    output logic             play_valid
);

    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CAP_C        = CNT_W'(CAPACITY);
    localparam logic [HR_W-1:0]  HOURS_C      = HR_W'(NUM_HOURS);
    localparam logic [HR_W-1:0]  LAST_HOUR_C  = HR_W'(NUM_HOURS - 1);
    localparam logic [HR_W-1:0]  NONE_C       = {HR_W{1'b1}};
    localparam logic [AD_W-1:0]  LAST_ADDR_C  = AD_W'(NUM_HOURS - 1);
    localparam logic [DW_W-1:0]  DWELL_LAST_C = DW_W'(DWELL - 1);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_PLAY_UP   = 2'd1,
        ST_PLAY_DOWN = 2'd2
    } state_t;

    state_t           state_r, state_nx_s;
    logic [CNT_W-1:0] count_r, count_nx_s, free_r, play_data_r, play_data_nx_s;
    logic [CNT_W-1:0] log_r [NUM_HOURS];
    logic [HR_W-1:0]  hour_r, hour_nx_s, rush_start_r, rush_start_nx_s, rush_end_r, rush_end_nx_s;
    logic [AD_W-1:0]  play_addr_r, addr_nx_s, hour_addr_s;
    logic [DW_W-1:0]  dwell_r, dwell_nx_s;
    logic             full_r, rejected_r, rejected_nx_s, day_done_r, rush_valid_r;
    logic             play_valid_r, play_valid_nx_s, log_we_s;

    assign hour_addr_s = hour_r[AD_W-1:0];

    // Next-state logic for occupancy, hour/log, rush bounds and playback sweep
    always_comb begin
        state_nx_s      = state_r;
        count_nx_s      = count_r;
        hour_nx_s       = hour_r;
        rejected_nx_s   = 1'b0;
        rush_start_nx_s = rush_start_r;
        rush_end_nx_s   = rush_end_r;
        log_we_s        = 1'b0;
        addr_nx_s       = play_addr_r;
        dwell_nx_s      = dwell_r;
        play_valid_nx_s = play_valid_r;
        case (state_r)
            ST_RUN: begin
                if (enter && !exit) begin
                    if (count_r == CAP_C) begin
                        rejected_nx_s = 1'b1;
                    end else begin
                        count_nx_s = count_r + CNT_W'(1);
                    end
                end else if (exit && !enter && (count_r != {CNT_W{1'b0}})) begin
                    count_nx_s = count_r - CNT_W'(1);
                end else begin
                    count_nx_s = count_r;
                end
                // Bounds use the pre-update hour; the end bound only arms once the start exists
                if ((count_nx_s == CAP_C) && (count_r != CAP_C) && (rush_start_r == NONE_C)) begin
                    rush_start_nx_s = hour_r;
                end else begin
                    rush_start_nx_s = rush_start_r;
                end
                if ((count_nx_s == {CNT_W{1'b0}}) && (count_r != {CNT_W{1'b0}}) &&
                    (rush_start_r != NONE_C) && (rush_end_r == NONE_C)) begin
                    rush_end_nx_s = hour_r;
                end else begin
                    rush_end_nx_s = rush_end_r;
                end
                if (hour_inc) begin
                    log_we_s  = 1'b1;
                    hour_nx_s = hour_r + HR_W'(1);
                end else begin
                    hour_nx_s = hour_r;
                end
                if (hour_inc && (hour_r == LAST_HOUR_C)) begin
                    state_nx_s      = ST_PLAY_UP;
                    addr_nx_s       = {AD_W{1'b0}};
                    dwell_nx_s      = {DW_W{1'b0}};
                    play_valid_nx_s = 1'b1;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_PLAY_UP: begin
                if (dwell_r == DWELL_LAST_C) begin
                    dwell_nx_s = {DW_W{1'b0}};
                    if (play_addr_r == LAST_ADDR_C) begin
                        if (NUM_HOURS > 2) begin
                            addr_nx_s  = LAST_ADDR_C - AD_W'(1);
                            state_nx_s = ST_PLAY_DOWN;
                        end else begin
                            addr_nx_s = {AD_W{1'b0}};
                        end
                    end else begin
                        addr_nx_s = play_addr_r + AD_W'(1);
                    end
                end else begin
                    dwell_nx_s = dwell_r + DW_W'(1);
                end
            end
            ST_PLAY_DOWN: begin
                if (dwell_r == DWELL_LAST_C) begin
                    dwell_nx_s = {DW_W{1'b0}};
                    if (play_addr_r == AD_W'(1)) begin
                        addr_nx_s  = {AD_W{1'b0}};
                        state_nx_s = ST_PLAY_UP;
                    end else begin
                        addr_nx_s = play_addr_r - AD_W'(1);
                    end
                end else begin
                    dwell_nx_s = dwell_r + DW_W'(1);
                end
            end
            default: begin
                state_nx_s = ST_RUN;
            end
        endcase
        // Bypass covers the final log write landing on the first replayed address
        if (!play_valid_nx_s) begin
            play_data_nx_s = {CNT_W{1'b0}};
        end else if (log_we_s && (hour_addr_s == addr_nx_s)) begin
            play_data_nx_s = count_r;
        end else begin
            play_data_nx_s = log_r[addr_nx_s];
        end
    end

    // State, log and registered-output update with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r      <= ST_RUN;
            count_r      <= {CNT_W{1'b0}};
            free_r       <= CAP_C;
            full_r       <= 1'b0;
            rejected_r   <= 1'b0;
            hour_r       <= {HR_W{1'b0}};
            day_done_r   <= 1'b0;
            rush_start_r <= NONE_C;
            rush_end_r   <= NONE_C;
            rush_valid_r <= 1'b0;
            play_addr_r  <= {AD_W{1'b0}};
            play_data_r  <= {CNT_W{1'b0}};
            play_valid_r <= 1'b0;
            dwell_r      <= {DW_W{1'b0}};
            for (int i = 0; i < NUM_HOURS; i++) begin
                log_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            state_r      <= state_nx_s;
            count_r      <= count_nx_s;
            free_r       <= CAP_C - count_nx_s;
            full_r       <= (count_nx_s == CAP_C);
            rejected_r   <= rejected_nx_s;
            hour_r       <= hour_nx_s;
            day_done_r   <= (hour_nx_s == HOURS_C);
            rush_start_r <= rush_start_nx_s;
            rush_end_r   <= rush_end_nx_s;
            rush_valid_r <= (hour_nx_s == HOURS_C) && (rush_start_nx_s != NONE_C) &&
                            (rush_end_nx_s != NONE_C);
            play_addr_r  <= addr_nx_s;
            play_data_r  <= play_data_nx_s;
            play_valid_r <= play_valid_nx_s;
            dwell_r      <= dwell_nx_s;
            if (log_we_s) begin
                log_r[hour_addr_s] <= count_r;
            end
        end
    end

    assign count      = count_r;
    assign free       = free_r;
    assign full       = full_r;
    assign rejected   = rejected_r;
    assign hour       = hour_r;
    assign day_done   = day_done_r;
    assign rush_start = rush_start_r;
    assign rush_end   = rush_end_r;
    assign rush_valid = rush_valid_r;
    assign play_addr  = play_addr_r;
    assign play_data  = play_data_r;
    assign play_valid = play_valid_r;

endmodule

// File: tb/tb_parking_lot_tracker.sv
// Scoreboard bench for parking_lot_tracker: a behavioural model pushes the expected
// post-edge view per cycle, a monitor pops and compares after each rising edge.
module tb_parking_lot_tracker;

    localparam int CAP = 3;
    localparam int NH  = 8;
    localparam int DW  = 2;
    localparam int ONES = 15;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0, enter = 1'b0, exit = 1'b0, hour_inc = 1'b0;
    logic [1:0] count, free, play_data;
    logic       full, rejected, day_done, rush_valid, play_valid;
    logic [3:0] hour, rush_start, rush_end;
    logic [2:0] play_addr;

    parking_lot_tracker #(.CAPACITY(CAP), .NUM_HOURS(NH), .DWELL(DW)) dut (
        .clock(clock), .reset_n(reset_n), .enter(enter), .exit(exit), .hour_inc(hour_inc),
        .count(count), .free(free), .full(full), .rejected(rejected), .hour(hour),
        .day_done(day_done), .rush_start(rush_start), .rush_end(rush_end),
        .rush_valid(rush_valid), .play_addr(play_addr), .play_data(play_data),
        .play_valid(play_valid)
    );

    always #5 clock = ~clock;

    typedef struct {
        int count, free, full, rej, hour, done, rs, re, rv, addr, data, pv;
    } exp_t;

    exp_t q[$];
    int n_vec = 0;
    int n_mis = 0;

    // model state: occupancy, hour, log, rush bounds, cycles since day end
    int m_c, m_h, m_rs, m_re, m_done, m_t, m_rej;
    int m_log [NH];

    task automatic chk(input string name, input int act, input int exp);
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clock) begin : monitor
        exp_t e;
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            chk("count", int'(count), e.count);
            chk("free", int'(free), e.free);
            chk("full", int'(full), e.full);
            chk("rejected", int'(rejected), e.rej);
            chk("hour", int'(hour), e.hour);
            chk("day_done", int'(day_done), e.done);
            chk("rush_start", int'(rush_start), e.rs);
            chk("rush_end", int'(rush_end), e.re);
            chk("rush_valid", int'(rush_valid), e.rv);
            chk("play_valid", int'(play_valid), e.pv);
            chk("play_addr", int'(play_addr), e.addr);
            chk("play_data", int'(play_data), e.data);
        end
    end

    // Apply one cycle of inputs, advance the model by one edge and queue the expectation
    task automatic cyc(input bit e, input bit x, input bit h, input bit rn);
        exp_t ex;
        int nc, step, pos, period;
        @(negedge clock);
        enter = e; exit = x; hour_inc = h; reset_n = rn;
        m_rej = 0;
        if (!rn) begin
            m_c = 0; m_h = 0; m_rs = ONES; m_re = ONES; m_done = 0; m_t = 0;
            for (int i = 0; i < NH; i++) m_log[i] = 0;
        end else if (!m_done) begin
            nc = m_c;
            if (e && !x) begin
                if (m_c == CAP) m_rej = 1; else nc = m_c + 1;
            end else if (x && !e && m_c > 0) begin
                nc = m_c - 1;
            end
            if (nc == 0 && m_c != 0 && m_rs != ONES && m_re == ONES) m_re = m_h;
            if (nc == CAP && m_c != CAP && m_rs == ONES) m_rs = m_h;
            if (h) begin
                m_log[m_h] = m_c;
                m_h++;
                if (m_h == NH) begin m_done = 1; m_t = 0; end
            end
            m_c = nc;
        end else begin
            m_t++;
        end
        ex.count = m_c; ex.free = CAP - m_c; ex.full = (m_c == CAP); ex.rej = m_rej;
        ex.hour = m_h; ex.done = m_done; ex.rs = m_rs; ex.re = m_re;
        ex.rv = m_done && m_rs != ONES && m_re != ONES;
        ex.pv = m_done;
        period = 2 * NH - 2;
        step = m_t / DW;
        pos = step % period;
        ex.addr = m_done ? ((pos < NH) ? pos : period - pos) : 0;
        ex.data = m_done ? m_log[ex.addr] : 0;
        q.push_back(ex);
    endtask

    task automatic set_count(input int target);
        while (m_c != target) begin
            case ($urandom_range(0, 3))
                0: cyc(1'b1, 1'b1, 1'b0, 1'b1);
                1: cyc(1'b0, 1'b0, 1'b0, 1'b1);
                default: if (m_c < target) cyc(1'b1, 1'b0, 1'b0, 1'b1);
                         else cyc(1'b0, 1'b1, 1'b0, 1'b1);
            endcase
        end
    endtask

    // Drive a whole day towards per-hour targets; rnd lets hour_inc coincide with enter/exit
    task automatic run_day(input int t [NH], input bit rnd);
        for (int hh = 0; hh < NH; hh++) begin
            set_count(t[hh]);
            if (rnd && $urandom_range(0, 2) == 0) cyc(1'b1, 1'b0, 1'b1, 1'b1);
            else if (rnd && $urandom_range(0, 2) == 0) cyc(1'b0, 1'b1, 1'b1, 1'b1);
            else cyc(1'b0, 1'b0, 1'b1, 1'b1);
        end
    endtask

    task automatic noise(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    endtask

    initial begin
        int d1 [NH] = '{0, 1, 3, 3, 3, 0, 0, 0};
        int d2 [NH] = '{1, 2, 3, 3, 2, 1, 1, 1};
        int d3 [NH] = '{0, 1, 2, 3, 3, 2, 1, 0};
        int dr [NH];
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        // fill, reject, simultaneous enter/exit, underflow guard
        repeat (4) cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        // rush 2..5 day, then ignored inputs after day end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        run_day(d1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        noise(10);
        // fills but never empties
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        run_day(d2, 1'b0);
        noise(4);
        // ramp log, full ping-pong sweep, reset mid-playback, then a random day
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        run_day(d3, 1'b0);
        noise(40);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NH; i++) dr[i] = $urandom_range(0, CAP);
            run_day(dr, 1'b1);
            noise(32);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
        // bounded drain of the scoreboard
        repeat (4) @(negedge clock);
        n_vec++;
        if (q.size() != 0) begin
            n_mis++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
